uf_parent_table: RTL and testbench

//  Responder for the union-find parent-table interface. Holds parent[] for all 49 syndrome

---
 rtl/uf_pkg.sv | 15 +
 rtl/uf_init_sequencer.sv | 33 +++
 rtl/uf_parent_table.sv | 113 +++++++++++
 tb/tb_uf_parent_table.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uf_pkg.sv
// Shared sizing and helpers for the union-find parent table.
// NODES entries hold parent pointers; every address and parent value is ADDR_W bits wide.
package uf_pkg;

    localparam int NODES  = 49;
    localparam int ADDR_W = 6;

    typedef logic [ADDR_W-1:0] node_t;

    // True when n names a real table entry.
    function automatic logic in_range(node_t n);
        return n < node_t'(NODES);
    endfunction

endpackage

// File: rtl/uf_init_sequencer.sv
// Identity sweep for the parent table: writes parent[cnt]=cnt once per cycle.
// The sweep restarts from entry 0 on reset or on init_start.
module uf_init_sequencer
    import uf_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  init_start,
    output logic  busy,
    output logic  sweep_we,
    output node_t sweep_addr
);

    node_t cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || init_start) begin
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            if (cnt == node_t'(NODES - 1)) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt + node_t'(1);
            end
        end
    end

    assign sweep_we   = busy;
    assign sweep_addr = cnt;

endmodule

// File: rtl/uf_parent_table.sv
// Parent-table responder for the union-find decoder: 1W1R array with write-first reads,
// one pending read and one pending write slot held across the identity sweep.
module uf_parent_table
    import uf_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              init_start,
    output logic              init_busy,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] rd_data,
    output logic              rd_ready,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] wr_data,
    output logic              wr_done,
    output logic              err_addr,
    output logic              err_overflow,
    input  logic              err_clear
);

    logic  sweep_we;
    node_t sweep_addr;

    uf_init_sequencer u_seq (
        .clk        (clk),
        .reset      (reset),
        .init_start (init_start),
        .busy       (init_busy),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr)
    );

    node_t mem [NODES];

    logic  rd_pend_v, wr_pend_v;
    node_t rd_pend_addr, wr_pend_addr, wr_pend_data;

    logic  rd_go, wr_go, wr_ok, rd_bad, wr_bad, ovf_new;
    node_t rd_a, wr_a, wr_d, rd_val;

    // A pending request always has priority over a fresh one; the fresh one refills the slot.
    always_comb begin
        rd_go  = !init_busy && !init_start && (rd_pend_v || rd_req);
        wr_go  = !init_busy && !init_start && (wr_pend_v || wr_req);
        rd_a   = rd_pend_v ? rd_pend_addr : rd_addr;
        wr_a   = wr_pend_v ? wr_pend_addr : wr_addr;
        wr_d   = wr_pend_v ? wr_pend_data : wr_data;
        rd_bad = !in_range(rd_a);
        wr_bad = !in_range(wr_a) || !in_range(wr_d);
        wr_ok  = wr_go && !wr_bad;
        ovf_new = init_busy && !init_start &&
                  ((rd_req && rd_pend_v) || (wr_req && wr_pend_v));
        // Out-of-range reads return their own address so find sees a root and stops.
        if (rd_bad) begin
            rd_val = rd_a;
        end else if (wr_ok && (wr_a == rd_a)) begin
            rd_val = wr_d;
        end else begin
            rd_val = mem[rd_a];
        end
    end

    // NOTE: the array has no reset; the identity sweep initialises it after every reset.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[sweep_addr] <= sweep_addr;
        end else if (wr_ok) begin
            mem[wr_a] <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ready     <= 1'b0;
            wr_done      <= 1'b0;
            rd_data      <= '0;
            err_addr     <= 1'b0;
            err_overflow <= 1'b0;
            rd_pend_v    <= 1'b0;
            wr_pend_v    <= 1'b0;
            rd_pend_addr <= '0;
            wr_pend_addr <= '0;
            wr_pend_data <= '0;
        end else begin
            rd_ready <= rd_go;
            wr_done  <= wr_go;
            if (rd_go) begin
                rd_data <= rd_val;
            end

            err_addr     <= (err_addr && !err_clear) || (rd_go && rd_bad) || (wr_go && wr_bad);
            err_overflow <= (err_overflow && !err_clear) || ovf_new;

            if (init_start) begin
                rd_pend_v <= 1'b0;
                wr_pend_v <= 1'b0;
            end else begin
                rd_pend_v <= init_busy ? (rd_pend_v || rd_req) : (rd_pend_v && rd_req);
                wr_pend_v <= init_busy ? (wr_pend_v || wr_req) : (wr_pend_v && wr_req);
                if (rd_req && (init_busy ? !rd_pend_v : rd_pend_v)) begin
                    rd_pend_addr <= rd_addr;
                end
                if (wr_req && (init_busy ? !wr_pend_v : wr_pend_v)) begin
                    wr_pend_addr <= wr_addr;
                    wr_pend_data <= wr_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_uf_parent_table.sv
// Directed self-checking bench for uf_parent_table: identity sweep, write-first reads,
// pending slots across the sweep, range errors, sticky flags and reset mid-sweep.
module tb_uf_parent_table;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          init_start;
    logic          init_busy;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] rd_data;
    logic          rd_ready;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] wr_data;
    logic          wr_done;
    logic          err_addr;
    logic          err_overflow;
    logic          err_clear;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uf_parent_table dut (
        .clk          (clk),
        .reset        (reset),
        .init_start   (init_start),
        .init_busy    (init_busy),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_ready     (rd_ready),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_done      (wr_done),
        .err_addr     (err_addr),
        .err_overflow (err_overflow),
        .err_clear    (err_clear)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Counts cycles with init_busy high (bounded) and any early responses seen meanwhile.
    task automatic wait_sweep(output int busy_cycles, output int early);
        busy_cycles = 0;
        early       = 0;
        while (init_busy && busy_cycles < 100) begin
            if (rd_ready || wr_done) early++;
            busy_cycles++;
            tick();
        end
    endtask

    task automatic read1(input logic [AW-1:0] a);
        rd_req  = 1'b1;
        rd_addr = a;
        tick();
        rd_req  = 1'b0;
    endtask

    task automatic write1(input logic [AW-1:0] a, input logic [AW-1:0] d);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_req  = 1'b0;
    endtask

    int nb, early;

    initial begin
        reset = 1'b1; init_start = 1'b0; err_clear = 1'b0;
        rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        ticks(3);
        check("reset_rd_ready", rd_ready, 0);
        check("reset_wr_done", wr_done, 0);
        check("reset_rd_data", rd_data, 0);
        check("reset_err_addr", err_addr, 0);
        check("reset_err_ovf", err_overflow, 0);

        // 1: sweep length after reset, then a plain read.
        reset = 1'b0;
        wait_sweep(nb, early);
        check("t1_busy_cycles", nb, 49);
        read1(6'd17);
        check("t1_rd_ready", rd_ready, 1);
        check("t1_rd_data", rd_data, 17);
        tick();
        check("t1_rd_ready_drop", rd_ready, 0);
        read1(6'd48);
        check("t1_rd_last_entry", rd_data, 48);
        check("t1_last_no_err", err_addr, 0);

        // 2: write then read-after-write, and same-cycle write-first.
        write1(6'd5, 6'd12);
        check("t2_wr_done", wr_done, 1);
        read1(6'd5);
        check("t2_raw_data", rd_data, 12);
        check("t2_wr_done_drop", wr_done, 0);
        rd_req = 1'b1; rd_addr = 6'd8;
        wr_req = 1'b1; wr_addr = 6'd8; wr_data = 6'd3;
        tick();
        rd_req = 1'b0; wr_req = 1'b0;
        check("t2_wf_data", rd_data, 3);
        check("t2_wf_rd_ready", rd_ready, 1);
        check("t2_wf_wr_done", wr_done, 1);

        // 3: requests captured during a sweep, overflow drop, drain.
        init_start = 1'b1; tick(); init_start = 1'b0;
        ticks(10);
        read1(6'd9);
        read1(6'd30);
        check("t3_overflow", err_overflow, 1);
        check("t3_no_early_rd", rd_ready, 0);
        write1(6'd12, 6'd33);
        wait_sweep(nb, early);
        check("t3_no_early_resp", early, 0);
        check("t3_drain_rd_ready", rd_ready, 0);
        tick();
        check("t3_drain1_rd_ready", rd_ready, 1);
        check("t3_drain1_rd_data", rd_data, 9);
        check("t3_drain1_wr_done", wr_done, 1);
        tick();
        check("t3_dropped_never", rd_ready, 0);
        read1(6'd12);
        check("t3_pending_wr_data", rd_data, 33);
        read1(6'd5);
        check("t3_sweep_restored", rd_data, 5);

        // 4: range errors and sticky flags.
        err_clear = 1'b1; tick(); err_clear = 1'b0;
        check("t4_ovf_cleared", err_overflow, 0);
        read1(6'd60);
        check("t4_oor_rd_data", rd_data, 60);
        check("t4_oor_rd_ready", rd_ready, 1);
        check("t4_err_addr", err_addr, 1);
        write1(6'd50, 6'd3);
        check("t4_oor_wr_done", wr_done, 1);
        read1(6'd50);
        check("t4_oor_unchanged", rd_data, 50);
        write1(6'd4, 6'd55);
        check("t4_bad_data_done", wr_done, 1);
        read1(6'd4);
        check("t4_bad_data_unchanged", rd_data, 4);
        read1(6'd49);
        check("t4_first_oor", rd_data, 49);
        err_clear = 1'b1; rd_req = 1'b1; rd_addr = 6'd63;
        tick();
        err_clear = 1'b0; rd_req = 1'b0;
        check("t4_clear_vs_new", err_addr, 1);
        err_clear = 1'b1; tick(); err_clear = 1'b0;
        check("t4_err_addr_clr", err_addr, 0);
        check("t4_err_ovf_clr", err_overflow, 0);

        // 5: init_start restores identity over a written entry.
        write1(6'd20, 6'd7);
        read1(6'd20);
        check("t5_written", rd_data, 7);
        init_start = 1'b1; tick(); init_start = 1'b0;
        wait_sweep(nb, early);
        check("t5_busy_cycles", nb, 49);
        read1(6'd20);
        check("t5_identity", rd_data, 20);

        // 6: reset in the middle of a sweep with a pending read.
        read1(6'd60);
        init_start = 1'b1; tick(); init_start = 1'b0;
        ticks(5);
        read1(6'd7);
        ticks(24);
        check("t6_mid_sweep_busy", init_busy, 1);
        reset = 1'b1; tick();
        check("t6_rst_rd_ready", rd_ready, 0);
        check("t6_rst_wr_done", wr_done, 0);
        check("t6_rst_rd_data", rd_data, 0);
        check("t6_rst_err_addr", err_addr, 0);
        check("t6_rst_err_ovf", err_overflow, 0);
        reset = 1'b0;
        wait_sweep(nb, early);
        check("t6_busy_cycles", nb, 49);
        check("t6_no_resp_sweep", early, 0);
        check("t6_drain_flushed", rd_ready, 0);
        tick();
        check("t6_drain1_flushed", rd_ready, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
